grf_wb_arbiter: RTL and testbench
=================================

# grf_wb_arbiter

Write-back arbiter for the single GRF write port of the pipelined MIPS core. It shares the port among three result producers: 0 = EX/ALU, 1 = MEM/load, 2 = MDU (mfhi/mflo/mult-div completion). It grants one producer per cycle using a round-robin scheme and registers the winning write. It then drives the GRF write inputs (A3, WD, WE, PCnow) on the following cycle.

## Interface
Parameters:
- DROP_ZERO, default 1: when 1, requests to register 0 are granted but produce no GRF write. When 0, they are forwarded with WE=1; the GRF ignores the data but logs the write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wb_stall  in  1  freezes arbitration. No grant is issued while it is high.
- req0, req1, req2  in  1 each  write-back request from producer k.
- addr0, addr1, addr2  in  5 each  destination register of producer k.
- data0, data1, data2  in  32 each  write data of producer k.
- pc0, pc1, pc2  in  32 each  PC of the instruction producing the write; used for the GRF log.
- gnt0, gnt1, gnt2  out  1 each  combinational grant. The request is consumed in the cycle gnt is high.
- grf_we  out  1  to GRF WE.
- grf_a3  out  5  to GRF A3.
- grf_wd  out  32  to GRF WD.
- grf_pc  out  32  to GRF PCnow.
- ptr  out  2  current round-robin pointer; exposed for debug and coverage.

## Operation
- Handshake:
  - A producer raises reqk with addrk/datak/pck valid.
  - It must hold all four stable until it samples gntk=1 on a rising edge.
  - It may drop reqk after that edge, or keep it high to present the next write.
- Arbitration:
  - Grants are combinational from req0..2, ptr and wb_stall.
  - The search order starts at index ptr and then wraps upward mod 3: ptr, ptr+1, ptr+2.
  - The first asserted req in that order receives gnt. At most one gnt is high per cycle.
  - No gnt is issued while reset or wb_stall is high.
- Pointer update:
  - On a grant to k, ptr <= (k+1) mod 3.
  - With no grant, ptr holds.
  - ptr only ever takes the values 0, 1 or 2.
- Output register:
  - On a grant, {grf_a3, grf_wd, grf_pc} <= {addrk, datak, pck} and grf_we <= 1.
  - Exception: when DROP_ZERO=1 and addrk=0, grf_we <= 0 and the address/data/pc fields still load.
  - With no grant, grf_we <= 0 and the other output fields hold their previous values.
- Starvation bound: a continuously requesting producer is granted within 3 non-stalled cycles.
- There is no write merging and no same-address ordering between producers. In-order retirement into the arbiter is the pipeline's responsibility.

## Timing
- Reset: on a rising edge with reset=1, the following take effect:
  - ptr=0
  - grf_we=0
  - grf_a3=0
  - grf_wd=0
  - grf_pc=0
  - All gnt outputs are forced to 0 during that cycle.
  - A request pending at reset mid-operation is not consumed and must be re-presented after reset.
- Latency:
  - A grant in cycle t produces grf_we=1 during cycle t+1.
  - The GRF commits the write at the end of cycle t+1, so the write is visible on RD1/RD2 in cycle t+2.
- Throughput: one write per cycle, sustained.
- wb_stall:
  - Rising: the output stage still completes the write granted in the previous cycle.
  - While high: grf_we=0 from the next cycle onward, and ptr holds.
- Simultaneous reset and wb_stall: reset wins.
- Requests arriving in the same cycle as a grant to another producer are considered from the next cycle under the updated ptr.

## Test plan
- Reset: assert reset with req0=req1=req2=1. All gnt stay 0, and after the edge ptr=0, grf_we=0, grf_a3=0. Release reset. The first cycle grants 0.
- Single write: req1, addr1=5, data1=0x1234_5678, pc1=0x3008, held for one cycle. gnt1=1 that cycle. Next cycle grf_we=1, grf_a3=5, grf_wd=0x12345678, grf_pc=0x3008, then grf_we=0. ptr=2.
- Round robin: all three requests held high for 6 cycles from ptr=0. Grant sequence is 0,1,2,0,1,2, and grf_we=1 for 6 consecutive cycles starting one cycle later.
- $0 drop: with DROP_ZERO=1, req0 with addr0=0 and data0=0xFFFF_FFFF. gnt0=1, and the next cycle has grf_we=0. Rerun with DROP_ZERO=0: grf_we=1, grf_a3=0.
- Stall: req2 held high with wb_stall=1 for 4 cycles. gnt2=0 throughout, grf_we=0, ptr unchanged. When wb_stall drops, gnt2=1 the same cycle.
- Reset mid-stream: req0 and req1 high; assert reset on the cycle gnt0 would fire. No write appears and ptr=0. After release, req0 is granted first.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// grf_wb_arbiter
//
// Shares the single GRF write port among three result producers
// (0 = EX/ALU, 1 = MEM/load, 2 = MDU). Each cycle, a round-robin search
// starting at ptr picks at most one requester. The winning write is
// registered and then drives the GRF write inputs in the following cycle.
//
// Parameters:
//   DROP_ZERO  1: a grant to register $0 loads the fields but keeps grf_we=0
//              0: a grant to register $0 is forwarded with grf_we=1
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wb_stall                   freezes arbitration (no grants, ptr holds)
//   req0..2                    write-back request of producer k
//   addr0..2 / data0..2 / pc0..2  destination, data and PC of producer k
//   gnt0..2                    combinational grant; request consumed this cycle
//   grf_we/grf_a3/grf_wd/grf_pc  registered GRF write port (WE, A3, WD, PCnow)
//   ptr                        round-robin pointer (0..2), debug/coverage
// ---------------------------------------------------------------------------
module grf_wb_arbiter #(
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stall,
    input  logic        req0,
    input  logic        req1,
    input  logic        req2,
    input  logic [4:0]  addr0,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] pc0,
    input  logic [31:0] pc1,
    input  logic [31:0] pc2,
    output logic        gnt0,
    output logic        gnt1,
    output logic        gnt2,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [1:0]  ptr
);

    logic [1:0]  ptr_q, ptr_d;
    logic        we_q, we_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] pc_q, pc_d;

    logic [2:0]  gnt_s;
    logic        gnt_any_s;
    logic [1:0]  gnt_idx_s;
    logic [4:0]  sel_addr_s;
    logic [31:0] sel_data_s;
    logic [31:0] sel_pc_s;

    // Round-robin grant: search ptr, ptr+1, ptr+2 (mod 3); reset/stall block all grants.
    always_comb begin
        gnt_s = 3'b000;
        if (reset || wb_stall) begin
            gnt_s = 3'b000;
        end else begin
            case (ptr_q)
                2'd1: begin
                    if (req1)      gnt_s = 3'b010;
                    else if (req2) gnt_s = 3'b100;
                    else if (req0) gnt_s = 3'b001;
                    else           gnt_s = 3'b000;
                end
                2'd2: begin
                    if (req2)      gnt_s = 3'b100;
                    else if (req0) gnt_s = 3'b001;
                    else if (req1) gnt_s = 3'b010;
                    else           gnt_s = 3'b000;
                end
                // ptr is never 3; treat it like 0 so a corrupted pointer still arbitrates.
                default: begin
                    if (req0)      gnt_s = 3'b001;
                    else if (req1) gnt_s = 3'b010;
                    else if (req2) gnt_s = 3'b100;
                    else           gnt_s = 3'b000;
                end
            endcase
        end
    end

    // Select the granted producer's write fields.
    always_comb begin
        gnt_any_s  = 1'b0;
        gnt_idx_s  = 2'd0;
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
        sel_pc_s   = 32'd0;
        case (gnt_s)
            3'b001: begin
                gnt_any_s  = 1'b1;
                gnt_idx_s  = 2'd0;
                sel_addr_s = addr0;
                sel_data_s = data0;
                sel_pc_s   = pc0;
            end
            3'b010: begin
                gnt_any_s  = 1'b1;
                gnt_idx_s  = 2'd1;
                sel_addr_s = addr1;
                sel_data_s = data1;
                sel_pc_s   = pc1;
            end
            3'b100: begin
                gnt_any_s  = 1'b1;
                gnt_idx_s  = 2'd2;
                sel_addr_s = addr2;
                sel_data_s = data2;
                sel_pc_s   = pc2;
            end
            default: begin
                gnt_any_s = 1'b0;
            end
        endcase
    end

    // Next pointer and next output-register contents.
    always_comb begin
        ptr_d = ptr_q;
        we_d  = 1'b0;
        a3_d  = a3_q;
        wd_d  = wd_q;
        pc_d  = pc_q;
        if (gnt_any_s) begin
            ptr_d = (gnt_idx_s == 2'd2) ? 2'd0 : (gnt_idx_s + 2'd1);
            a3_d  = sel_addr_s;
            wd_d  = sel_data_s;
            pc_d  = sel_pc_s;
            // $0 writes still load the fields so the log path sees them.
            we_d  = !(DROP_ZERO && (sel_addr_s == 5'd0));
        end else begin
            ptr_d = ptr_q;
            we_d  = 1'b0;
        end
    end

    // Pointer and GRF write-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
            we_q  <= 1'b0;
            a3_q  <= 5'd0;
            wd_q  <= 32'd0;
            pc_q  <= 32'd0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= we_d;
            a3_q  <= a3_d;
            wd_q  <= wd_d;
            pc_q  <= pc_d;
        end
    end

    assign gnt0   = gnt_s[0];
    assign gnt1   = gnt_s[1];
    assign gnt2   = gnt_s[2];
    assign grf_we = we_q;
    assign grf_a3 = a3_q;
    assign grf_wd = wd_q;
    assign grf_pc = pc_q;
    assign ptr    = ptr_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset, wb_stall;
    logic        req0, req1, req2;
    logic [4:0]  addr0, addr1, addr2;
    logic [31:0] data0, data1, data2;
    logic [31:0] pc0, pc1, pc2;

    logic        gnt0, gnt1, gnt2, grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic [1:0]  ptr;

    logic        nz_gnt0, nz_gnt1, nz_gnt2, nz_we;
    logic [4:0]  nz_a3;
    logic [31:0] nz_wd, nz_pc;
    logic [1:0]  nz_ptr;

    logic [2:0]  gnt_v;
    int          checks = 0;
    int          failures = 0;

    assign gnt_v = {gnt2, gnt1, gnt0};

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DROP_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .wb_stall(wb_stall),
        .req0(req0), .req1(req1), .req2(req2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .pc0(pc0), .pc1(pc1), .pc2(pc2),
        .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .ptr(ptr)
    );

    grf_wb_arbiter #(.DROP_ZERO(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .wb_stall(wb_stall),
        .req0(req0), .req1(req1), .req2(req2),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .data0(data0), .data1(data1), .data2(data2),
        .pc0(pc0), .pc1(pc1), .pc2(pc2),
        .gnt0(nz_gnt0), .gnt1(nz_gnt1), .gnt2(nz_gnt2),
        .grf_we(nz_we), .grf_a3(nz_a3), .grf_wd(nz_wd), .grf_pc(nz_pc),
        .ptr(nz_ptr)
    );

    // Advance to just after the next rising edge; inputs change here, outputs settle by +1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    endtask

    task automatic do_reset();
        clear_reqs();
        wb_stall = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_stall = 1'b0;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        addr0 = 5'd7; data0 = 32'hAAAA_0000; pc0 = 32'h0000_3000;
        #1;
        checks++; if (gnt_v !== 3'b000) begin failures++; $display("FAIL reset_gnt got %b exp 000", gnt_v); end
        step();
        checks++; if (gnt_v !== 3'b000) begin failures++; $display("FAIL reset_gnt_hold got %b exp 000", gnt_v); end
        checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got %0d exp 0", ptr); end
        checks++; if (grf_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", grf_we); end
        checks++; if (grf_a3 !== 5'd0) begin failures++; $display("FAIL reset_a3 got %0d exp 0", grf_a3); end
        checks++; if (grf_wd !== 32'd0) begin failures++; $display("FAIL reset_wd got %h exp 0", grf_wd); end
        checks++; if (grf_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got %h exp 0", grf_pc); end
        reset = 1'b0;
        #1;
        checks++; if (gnt_v !== 3'b001) begin failures++; $display("FAIL reset_first_gnt got %b exp 001", gnt_v); end
        step();
        checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd7) begin failures++; $display("FAIL reset_first_write got we=%b a3=%0d exp we=1 a3=7", grf_we, grf_a3); end
        checks++; if (ptr !== 2'd1) begin failures++; $display("FAIL reset_first_ptr got %0d exp 1", ptr); end
        clear_reqs();
    endtask

    task automatic test_single_write();
        do_reset();
        req1 = 1'b1; addr1 = 5'd5; data1 = 32'h1234_5678; pc1 = 32'h0000_3008;
        #1;
        checks++; if (gnt_v !== 3'b010) begin failures++; $display("FAIL single_gnt got %b exp 010", gnt_v); end
        step();
        req1 = 1'b0;
        checks++; if (grf_we !== 1'b1) begin failures++; $display("FAIL single_we got %b exp 1", grf_we); end
        checks++; if (grf_a3 !== 5'd5) begin failures++; $display("FAIL single_a3 got %0d exp 5", grf_a3); end
        checks++; if (grf_wd !== 32'h1234_5678) begin failures++; $display("FAIL single_wd got %h exp 12345678", grf_wd); end
        checks++; if (grf_pc !== 32'h0000_3008) begin failures++; $display("FAIL single_pc got %h exp 00003008", grf_pc); end
        checks++; if (ptr !== 2'd2) begin failures++; $display("FAIL single_ptr got %0d exp 2", ptr); end
        step();
        checks++; if (grf_we !== 1'b0) begin failures++; $display("FAIL single_we_drop got %b exp 0", grf_we); end
        checks++; if (grf_a3 !== 5'd5 || grf_wd !== 32'h1234_5678) begin failures++; $display("FAIL single_hold got a3=%0d wd=%h exp a3=5 wd=12345678", grf_a3, grf_wd); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [6];
        logic [4:0] exp_a3 [6];
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
        exp_gnt[3] = 3'b001; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b100;
        exp_a3[0] = 5'd1; exp_a3[1] = 5'd2; exp_a3[2] = 5'd3;
        exp_a3[3] = 5'd1; exp_a3[4] = 5'd2; exp_a3[5] = 5'd3;
        do_reset();
        addr0 = 5'd1; data0 = 32'h0000_0A00; pc0 = 32'h0000_3100;
        addr1 = 5'd2; data1 = 32'h0000_0B00; pc1 = 32'h0000_3104;
        addr2 = 5'd3; data2 = 32'h0000_0C00; pc2 = 32'h0000_3108;
        req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (gnt_v !== exp_gnt[i]) begin failures++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt_v, exp_gnt[i]); end
            step();
            if (i == 5) clear_reqs();
            checks++; if (grf_we !== 1'b1 || grf_a3 !== exp_a3[i]) begin failures++; $display("FAIL rr_write[%0d] got we=%b a3=%0d exp we=1 a3=%0d", i, grf_we, grf_a3, exp_a3[i]); end
        end
        step();
        checks++; if (grf_we !== 1'b0) begin failures++; $display("FAIL rr_idle_we got %b exp 0", grf_we); end
        checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL rr_ptr got %0d exp 0", ptr); end
    endtask

    task automatic test_drop_zero();
        do_reset();
        req0 = 1'b1; addr0 = 5'd0; data0 = 32'hFFFF_FFFF; pc0 = 32'h0000_3200;
        #1;
        checks++; if (gnt0 !== 1'b1 || nz_gnt0 !== 1'b1) begin failures++; $display("FAIL zero_gnt got %b/%b exp 1/1", gnt0, nz_gnt0); end
        step();
        req0 = 1'b0;
        checks++; if (grf_we !== 1'b0) begin failures++; $display("FAIL zero_drop_we got %b exp 0", grf_we); end
        checks++; if (grf_wd !== 32'hFFFF_FFFF || grf_pc !== 32'h0000_3200) begin failures++; $display("FAIL zero_drop_fields got wd=%h pc=%h exp ffffffff/00003200", grf_wd, grf_pc); end
        checks++; if (ptr !== 2'd1) begin failures++; $display("FAIL zero_drop_ptr got %0d exp 1", ptr); end
        checks++; if (nz_we !== 1'b1 || nz_a3 !== 5'd0) begin failures++; $display("FAIL zero_keep got we=%b a3=%0d exp we=1 a3=0", nz_we, nz_a3); end
        checks++; if (nz_wd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_keep_wd got %h exp ffffffff", nz_wd); end
    endtask

    task automatic test_stall();
        do_reset();
        req0 = 1'b1; addr0 = 5'd9; data0 = 32'h0000_0099; pc0 = 32'h0000_3300;
        #1;
        checks++; if (gnt_v !== 3'b001) begin failures++; $display("FAIL stall_pre_gnt got %b exp 001", gnt_v); end
        step();
        // Stall rises: write granted last cycle still completes.
        req0 = 1'b0; wb_stall = 1'b1;
        req2 = 1'b1; addr2 = 5'd17; data2 = 32'hCAFE_0002; pc2 = 32'h0000_3304;
        #1;
        checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd9) begin failures++; $display("FAIL stall_complete got we=%b a3=%0d exp we=1 a3=9", grf_we, grf_a3); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gnt_v !== 3'b000) begin failures++; $display("FAIL stall_gnt[%0d] got %b exp 000", i, gnt_v); end
            step();
            checks++; if (grf_we !== 1'b0 || ptr !== 2'd1) begin failures++; $display("FAIL stall_hold[%0d] got we=%b ptr=%0d exp we=0 ptr=1", i, grf_we, ptr); end
        end
        wb_stall = 1'b0;
        #1;
        checks++; if (gnt_v !== 3'b100) begin failures++; $display("FAIL stall_release_gnt got %b exp 100", gnt_v); end
        step();
        req2 = 1'b0;
        checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd17 || grf_wd !== 32'hCAFE_0002) begin failures++; $display("FAIL stall_release_write got we=%b a3=%0d wd=%h exp 1/17/cafe0002", grf_we, grf_a3, grf_wd); end
        checks++; if (ptr !== 2'd0) begin failures++; $display("FAIL stall_release_ptr got %0d exp 0", ptr); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        // Move ptr to 2 so the pending reset hits a non-trivial pointer.
        req1 = 1'b1; addr1 = 5'd4; data1 = 32'h0000_0044; pc1 = 32'h0000_3400;
        step();
        req1 = 1'b0;
        checks++; if (ptr !== 2'd2) begin failures++; $display("FAIL mid_setup_ptr got %0d exp 2", ptr); end
        step();
        req0 = 1'b1; addr0 = 5'd6; data0 = 32'h0000_0066; pc0 = 32'h0000_3404;
        req1 = 1'b1;
        reset = 1'b1; wb_stall = 1'b1;
        #1;
        checks++; if (gnt_v !== 3'b000) begin failures++; $display("FAIL mid_reset_gnt got %b exp 000", gnt_v); end
        step();
        wb_stall = 1'b0;
        checks++; if (grf_we !== 1'b0 || ptr !== 2'd0) begin failures++; $display("FAIL mid_reset_state got we=%b ptr=%0d exp we=0 ptr=0", grf_we, ptr); end
        reset = 1'b0;
        #1;
        checks++; if (gnt_v !== 3'b001) begin failures++; $display("FAIL mid_release_gnt got %b exp 001", gnt_v); end
        step();
        clear_reqs();
        checks++; if (grf_we !== 1'b1 || grf_a3 !== 5'd6 || ptr !== 2'd1) begin failures++; $display("FAIL mid_release_write got we=%b a3=%0d ptr=%0d exp 1/6/1", grf_we, grf_a3, ptr); end
    endtask

    initial begin
        reset = 1'b1; wb_stall = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        addr0 = 5'd0; addr1 = 5'd0; addr2 = 5'd0;
        data0 = 32'd0; data1 = 32'd0; data2 = 32'd0;
        pc0 = 32'd0; pc1 = 32'd0; pc2 = 32'd0;
        step();
        test_reset();
        test_single_write();
        test_round_robin();
        test_drop_zero();
        test_stall();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
